// File: rtl/orv64_ptw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : orv64_ptw_pkg
// Description : Types, constants and helpers shared by the Sv39 page-table
//               walker and its PTE decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package orv64_ptw_pkg;

    localparam int ORV64_PTE_SIZE_LOG2 = 3;
    localparam int ORV64_PADDR_WIDTH   = 56;
    localparam int ORV64_PPN_WIDTH     = 44;

    typedef enum logic [1:0] {
        ORV64_ACCESS_FETCH = 2'd0,
        ORV64_ACCESS_LOAD  = 2'd1,
        ORV64_ACCESS_STORE = 2'd2,
        ORV64_ACCESS_AMO   = 2'd3
    } orv64_access_type_e;

    typedef enum logic [4:0] {
        ORV64_EXCP_CAUSE_INST_ACCESS_FAULT  = 5'd1,
        ORV64_EXCP_CAUSE_LOAD_ACCESS_FAULT  = 5'd5,
        ORV64_EXCP_CAUSE_STORE_ACCESS_FAULT = 5'd7,
        ORV64_EXCP_CAUSE_INST_PAGE_FAULT    = 5'd12,
        ORV64_EXCP_CAUSE_LOAD_PAGE_FAULT    = 5'd13,
        ORV64_EXCP_CAUSE_STORE_PAGE_FAULT   = 5'd15,
        ORV64_EXCP_CAUSE_NONE               = 5'd31
    } orv64_excp_cause_e;

    typedef struct packed {
        logic [3:0]                 mode;
        logic [15:0]                asid;
        logic [ORV64_PPN_WIDTH-1:0] ppn;
    } orv64_csr_satp_t;

    typedef struct packed {
        logic [9:0]                 reserved;
        logic [ORV64_PPN_WIDTH-1:0] ppn;
        logic [1:0]                 rsw;
        logic                       d;
        logic                       a;
        logic                       g;
        logic                       u;
        logic                       x;
        logic                       w;
        logic                       r;
        logic                       v;
    } orv64_pte_t;

    typedef struct packed {
        logic [26:0]        req_vpn;
        orv64_access_type_e req_access_type;
    } orv64_tlb_ptw_if_req_t;

    typedef struct packed {
        orv64_pte_t         resp_pte;
        logic [1:0]         resp_lvl;
        logic               resp_excp_valid;
        orv64_excp_cause_e  resp_excp_cause;
    } orv64_tlb_ptw_if_resp_t;

    typedef struct packed {
        logic [ORV64_PADDR_WIDTH-1:0] paddr;
    } orv64_ptw_mem_req_t;

    typedef logic [2:0] orv64_ptw_state_e;

    localparam orv64_ptw_state_e ST_IDLE     = 3'd0;
    localparam orv64_ptw_state_e ST_MEM_REQ  = 3'd1;
    localparam orv64_ptw_state_e ST_MEM_WAIT = 3'd2;
    localparam orv64_ptw_state_e ST_CHECK    = 3'd3;
    localparam orv64_ptw_state_e ST_RESP     = 3'd4;

    function automatic orv64_excp_cause_e orv64_fault_cause(
        input orv64_access_type_e access_type,
        input logic               is_access_fault
    );
        orv64_excp_cause_e cause;
        if (access_type == ORV64_ACCESS_FETCH)
            cause = is_access_fault ? ORV64_EXCP_CAUSE_INST_ACCESS_FAULT : ORV64_EXCP_CAUSE_INST_PAGE_FAULT;
        else if (access_type == ORV64_ACCESS_LOAD)
            cause = is_access_fault ? ORV64_EXCP_CAUSE_LOAD_ACCESS_FAULT : ORV64_EXCP_CAUSE_LOAD_PAGE_FAULT;
        else
            cause = is_access_fault ? ORV64_EXCP_CAUSE_STORE_ACCESS_FAULT : ORV64_EXCP_CAUSE_STORE_PAGE_FAULT;
        return cause;
    endfunction

endpackage
`default_nettype wire

// File: rtl/orv64_pte_decode.sv
`default_nettype none
// ============================================================================
// Module      : orv64_pte_decode
// Description : Classifies one fetched PTE as leaf / pointer / structural fault.
// Revision    : 1.0 - initial release
// ============================================================================
module orv64_pte_decode
    import orv64_ptw_pkg::*;
(
    input  orv64_pte_t         pte,
    input  logic [1:0]         lvl,
    input  logic               mem_err,
    input  orv64_access_type_e access_type,
    output logic               is_leaf,
    output logic               excp_valid,
    output orv64_excp_cause_e  excp_cause
);

    logic w_misaligned;
    logic w_page_fault;
    logic w_unused;

    // A superpage leaf must have the PPN bits it spans cleared.
    always_comb begin
        w_misaligned = 1'b0;
        case (lvl)
            2'd1:    w_misaligned = |pte.ppn[8:0];
            2'd2:    w_misaligned = |pte.ppn[17:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    assign is_leaf      = pte.r | pte.x;
    assign w_page_fault = ~pte.v | (~pte.r & pte.w) | (is_leaf & w_misaligned)
                        | (~is_leaf & (lvl == 2'd0));
    assign excp_valid   = mem_err | w_page_fault;

    always_comb begin
        excp_cause = ORV64_EXCP_CAUSE_NONE;
        if (mem_err)
            excp_cause = orv64_fault_cause(access_type, 1'b1);
        else if (w_page_fault)
            excp_cause = orv64_fault_cause(access_type, 1'b0);
    end

    assign w_unused = ^{pte.reserved, pte.rsw, pte.d, pte.a, pte.g, pte.u, pte.ppn[43:18]};

endmodule
`default_nettype wire

// File: rtl/orv64_ptw.sv
`default_nettype none
// ============================================================================
// Module      : orv64_ptw
// Description : Sv39 hardware page-table walker, one outstanding walk.
// Revision    : 1.0 - initial release
// ============================================================================
module orv64_ptw
    import orv64_ptw_pkg::*;
#(
    parameter int unsigned PADDR_WIDTH = 56,
    parameter int unsigned MAX_LVL     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  orv64_csr_satp_t        satp,
    input  logic                   tlb2ptw_req_valid,
    input  orv64_tlb_ptw_if_req_t  tlb2ptw_req,
    output logic                   ptw2tlb_req_ready,
    output logic                   ptw2tlb_resp_valid,
    output orv64_tlb_ptw_if_resp_t ptw2tlb_resp,
    input  logic                   tlb2ptw_resp_ready,
    output logic                   ptw2mem_req_valid,
    output logic [PADDR_WIDTH-1:0] ptw2mem_req_paddr,
    input  logic                   mem2ptw_req_ready,
    input  logic                   mem2ptw_resp_valid,
    input  logic [63:0]            mem2ptw_resp_data,
    input  logic                   mem2ptw_resp_err,
    output logic                   ptw2mem_resp_ready
);

    orv64_ptw_state_e       r_state;
    logic [1:0]             r_lvl;
    logic [26:0]            r_vpn;
    orv64_access_type_e     r_access_type;
    logic [PADDR_WIDTH-1:0] r_paddr;
    orv64_pte_t             r_pte;
    logic                   r_mem_err;
    orv64_tlb_ptw_if_resp_t r_resp;

    logic                   w_is_leaf;
    logic                   w_excp_valid;
    orv64_excp_cause_e      w_excp_cause;
    logic                   w_unused_satp;

    function automatic logic [PADDR_WIDTH-1:0] pte_addr(
        input logic [ORV64_PPN_WIDTH-1:0] base,
        input logic [26:0]                vpn,
        input logic [1:0]                 lvl
    );
        logic [8:0]  idx;
        logic [63:0] sum;
        case (lvl)
            2'd2:    idx = vpn[26:18];
            2'd1:    idx = vpn[17:9];
            default: idx = vpn[8:0];
        endcase
        sum = {8'd0, base, 12'd0} + 64'({idx, {ORV64_PTE_SIZE_LOG2{1'b0}}});
        return sum[PADDR_WIDTH-1:0];
    endfunction

    orv64_pte_decode u_pte_decode (
        .pte         (r_pte),
        .lvl         (r_lvl),
        .mem_err     (r_mem_err),
        .access_type (r_access_type),
        .is_leaf     (w_is_leaf),
        .excp_valid  (w_excp_valid),
        .excp_cause  (w_excp_cause)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_lvl         <= '0;
            r_vpn         <= '0;
            r_access_type <= ORV64_ACCESS_FETCH;
            r_paddr       <= '0;
            r_pte         <= '0;
            r_mem_err     <= 1'b0;
            r_resp        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Root is sampled here only, so later satp writes cannot disturb the walk.
                    if (tlb2ptw_req_valid) begin
                        r_lvl         <= MAX_LVL[1:0];
                        r_vpn         <= tlb2ptw_req.req_vpn;
                        r_access_type <= tlb2ptw_req.req_access_type;
                        r_paddr       <= pte_addr(satp.ppn, tlb2ptw_req.req_vpn, MAX_LVL[1:0]);
                        r_state       <= ST_MEM_REQ;
                    end
                end
                ST_MEM_REQ: begin
                    if (mem2ptw_req_ready)
                        r_state <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (mem2ptw_resp_valid) begin
                        r_pte     <= mem2ptw_resp_data;
                        r_mem_err <= mem2ptw_resp_err;
                        r_state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_excp_valid || w_is_leaf) begin
                        r_resp.resp_pte        <= w_excp_valid ? '0 : r_pte;
                        r_resp.resp_lvl        <= r_lvl;
                        r_resp.resp_excp_valid <= w_excp_valid;
                        r_resp.resp_excp_cause <= w_excp_cause;
                        r_state                <= ST_RESP;
                    end else begin
                        r_lvl   <= r_lvl - 2'd1;
                        r_paddr <= pte_addr(r_pte.ppn, r_vpn, r_lvl - 2'd1);
                        r_state <= ST_MEM_REQ;
                    end
                end
                ST_RESP: begin
                    if (tlb2ptw_resp_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ptw2tlb_req_ready  = (r_state == ST_IDLE);
    assign ptw2tlb_resp_valid = (r_state == ST_RESP);
    assign ptw2tlb_resp       = r_resp;
    assign ptw2mem_req_valid  = (r_state == ST_MEM_REQ);
    assign ptw2mem_req_paddr  = r_paddr;
    assign ptw2mem_resp_ready = (r_state == ST_MEM_WAIT);

    assign w_unused_satp = ^{satp.mode, satp.asid};

    a_resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        mem2ptw_resp_valid |-> (r_state == ST_MEM_WAIT));

endmodule
`default_nettype wire
